// File: rtl/zap_sync_fifo_pkg.sv
// Shared constants and pointer helpers for the zap_sync_fifo queue.
// Used by zap_sync_fifo and its storage sub-module.
package zap_sync_fifo_pkg;

  localparam int unsigned ZAP_FIFO_DEF_WIDTH = 32'd70;
  localparam int unsigned ZAP_FIFO_DEF_DEPTH = 32'd32;

  // Full when the index bits match but the wrap bit (bit aw) differs.
  function automatic logic ptr_full(input logic [31:0] wptr,
                                    input logic [31:0] rptr,
                                    input int unsigned aw);
    logic [31:0] diff;
    logic [31:0] mask;
    diff = wptr ^ rptr;
    mask = (32'd1 << aw) - 32'd1;
    return ((diff & mask) == 32'd0) && ((diff & (32'd1 << aw)) != 32'd0);
  endfunction

endpackage

// File: rtl/zap_sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module zap_sync_fifo_mem
  import zap_sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ZAP_FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = ZAP_FIFO_DEF_DEPTH,
  parameter int unsigned AW    = $clog2(ZAP_FIFO_DEF_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_r[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_r[i_rd_addr];

endmodule

// File: rtl/zap_sync_fifo.sv
// Single-clock FIFO with registered (FWFT=0) or fall-through (FWFT=1) read data.
// Define ZAP_SYNC_FIFO_CHECKS_EN to compile in simulation-only overflow/underflow checks.
`ifdef ZAP_SYNC_FIFO_CHECKS_EN
module zap_sync_fifo_chk #(
  parameter int unsigned DEPTH = 32'd32,
  parameter int unsigned PW    = 32'd6
) (
  input logic          i_clk,
  input logic          i_reset,
  input logic          i_wr_en,
  input logic          i_ack,
  input logic          i_full,
  input logic          i_empty,
  input logic [PW-1:0] i_wptr,
  input logic [PW-1:0] i_rptr
);

  logic [PW-1:0] diff_s;
  assign diff_s = i_wptr - i_rptr;

  // Flag protocol misuse and impossible pointer spacing outside reset.
  always @(posedge i_clk) begin
    if (i_reset) begin
      if (i_wr_en && i_full)
        $error("[%0t] %m: overflow, write while full", $time);
      if (i_ack && i_empty)
        $error("[%0t] %m: underflow, read while empty", $time);
      if (32'(diff_s) > DEPTH)
        $error("[%0t] %m: pointer difference %0d exceeds depth", $time, diff_s);
    end
  end

endmodule
`endif

module zap_sync_fifo
  import zap_sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ZAP_FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = ZAP_FIFO_DEF_DEPTH,
  parameter bit          FWFT  = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ack,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_empty_n,
  output logic             o_full_n,
  output logic             o_full_n_nxt
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   PW       = AW + 32'd1;
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [PW-1:0]    wptr_nxt_s;
  logic [PW-1:0]    rptr_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             empty_nxt_s;
  logic             full_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic             empty_n_r;
  logic             full_n_r;
  logic [WIDTH-1:0] rd_data_s;

  // Gate requests with the registered flags and form next-state pointers.
  always_comb begin
    push_s     = 1'b0;
    pop_s      = 1'b0;
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    if (!i_reset) begin
      wptr_nxt_s = PTR_ZERO;
      rptr_nxt_s = PTR_ZERO;
    end else begin
      push_s = i_wr_en && !full_r;
      pop_s  = i_ack && !empty_r;
      if (push_s) begin
        wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (pop_s) begin
        rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        rptr_nxt_s = rptr_r;
      end
    end
    empty_nxt_s = (wptr_nxt_s == rptr_nxt_s);
    full_nxt_s  = ptr_full(32'(wptr_nxt_s), 32'(rptr_nxt_s), AW);
  end

  // Pointer and flag registers; flags follow the next-state pointers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wptr_r    <= PTR_ZERO;
      rptr_r    <= PTR_ZERO;
      empty_r   <= 1'b1;
      empty_n_r <= 1'b0;
      full_r    <= 1'b0;
      full_n_r  <= 1'b1;
    end else begin
      wptr_r    <= wptr_nxt_s;
      rptr_r    <= rptr_nxt_s;
      empty_r   <= empty_nxt_s;
      empty_n_r <= !empty_nxt_s;
      full_r    <= full_nxt_s;
      full_n_r  <= !full_nxt_s;
    end
  end

  zap_sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (push_s),
    .i_wr_addr (wptr_r[AW-1:0]),
    .i_wr_data (i_data),
    .i_rd_addr (rptr_r[AW-1:0]),
    .o_rd_data (rd_data_s)
  );

  generate
    if (FWFT) begin : g_fwft
      assign o_data = rd_data_s;
    end else begin : g_reg_data
      logic [WIDTH-1:0] data_r;

      // Capture the head entry as it is popped.
      always_ff @(posedge i_clk) begin
        if (!i_reset) begin
          data_r <= {WIDTH{1'b0}};
        end else if (pop_s) begin
          data_r <= rd_data_s;
        end else begin
          data_r <= data_r;
        end
      end

      assign o_data = data_r;
    end
  endgenerate

  assign o_empty      = empty_r;
  assign o_empty_n    = empty_n_r;
  assign o_full       = full_r;
  assign o_full_n     = full_n_r;
  assign o_full_n_nxt = !full_nxt_s;

`ifdef ZAP_SYNC_FIFO_CHECKS_EN
  zap_sync_fifo_chk #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_chk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr_en (i_wr_en),
    .i_ack   (i_ack),
    .i_full  (full_r),
    .i_empty (empty_r),
    .i_wptr  (wptr_r),
    .i_rptr  (rptr_r)
  );
`endif

endmodule

// File: tb/tb_zap_sync_fifo.sv
// Directed + random bench for zap_sync_fifo, both read-data modes side by side.
// A queue-based model predicts occupancy, flags and data order.
module tb_zap_sync_fifo;

  localparam int unsigned W = 32'd70;
  localparam int unsigned D = 32'd32;

  logic         clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_ack = 1'b0;
  logic         i_wr_en = 1'b0;
  logic [W-1:0] i_data = '0;

  logic [W-1:0] r_data, f_data;
  logic r_empty, r_full, r_empty_n, r_full_n, r_full_n_nxt;
  logic f_empty, f_full, f_empty_n, f_full_n, f_full_n_nxt;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_rdata = '0;

  always #5 clk = ~clk;

  zap_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) dut_reg (
    .i_clk(clk), .i_reset(i_reset), .i_ack(i_ack), .i_wr_en(i_wr_en),
    .i_data(i_data), .o_data(r_data), .o_empty(r_empty), .o_full(r_full),
    .o_empty_n(r_empty_n), .o_full_n(r_full_n), .o_full_n_nxt(r_full_n_nxt)
  );

  zap_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) dut_fwft (
    .i_clk(clk), .i_reset(i_reset), .i_ack(i_ack), .i_wr_en(i_wr_en),
    .i_data(i_data), .o_data(f_data), .o_empty(f_empty), .o_full(f_full),
    .o_empty_n(f_empty_n), .o_full_n(f_full_n), .o_full_n_nxt(f_full_n_nxt)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // One clock: drive, check the look-ahead flag, clock, update model, check state.
  task automatic step(input logic rst_n, input logic wr, input logic ack, input logic [W-1:0] d);
    int  sz;
    int  sz_after;
    bit  push_ok;
    bit  pop_ok;
    sz       = model_q.size();
    i_reset  = rst_n;
    i_wr_en  = wr;
    i_ack    = ack;
    i_data   = d;
    push_ok  = rst_n && wr && (sz < D);
    pop_ok   = rst_n && ack && (sz > 0);
    sz_after = rst_n ? (sz + int'(push_ok) - int'(pop_ok)) : 0;
    #1;
    chk_bit("reg_full_n_nxt", r_full_n_nxt, sz_after != D);
    chk_bit("fwft_full_n_nxt", f_full_n_nxt, sz_after != D);
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
      exp_rdata = '0;
    end else begin
      if (pop_ok) exp_rdata = model_q.pop_front();
      if (push_ok) model_q.push_back(d);
    end
    #1;
    sz = model_q.size();
    chk_bit("reg_empty", r_empty, sz == 0);
    chk_bit("reg_empty_n", r_empty_n, sz != 0);
    chk_bit("reg_full", r_full, sz == D);
    chk_bit("reg_full_n", r_full_n, sz != D);
    chk_bit("fwft_empty", f_empty, sz == 0);
    chk_bit("fwft_full", f_full, sz == D);
    chk_data("reg_data", r_data, exp_rdata);
    if (sz > 0) chk_data("fwft_head", f_data, model_q[0]);
  endtask

  initial begin
    logic [W-1:0] v;

    // Reset held for two cycles, then released.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, rand_data());
    step(1'b1, 1'b0, 1'b0, '0);

    // Single push / pop of 0x15.
    v = W'(8'h15);
    step(1'b1, 1'b1, 1'b0, v);
    step(1'b1, 1'b0, 1'b1, '0);
    chk_data("single_pop", r_data, v);
    step(1'b1, 1'b0, 1'b1, '0);

    // Fill to full, attempt overflow, drain in order.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0, W'(i));
    step(1'b1, 1'b1, 1'b0, W'(8'h3F));
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk_data("drain_order", r_data, W'(i));
    end

    // Two rounds of 20 to cross the pointer wrap.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, rand_data());
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, '0);
    end

    // Simultaneous push/pop while full, then at occupancy 5.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0, rand_data());
    step(1'b1, 1'b1, 1'b1, rand_data());
    chk_bit("full_cleared", r_full, 1'b0);
    while (model_q.size() > 5) step(1'b1, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, rand_data());
    chk_bit("occ5_not_empty", r_empty, 1'b0);
    while (model_q.size() > 0) step(1'b1, 1'b0, 1'b1, '0);

    // Fall-through: 0xA then 0xB.
    step(1'b1, 1'b1, 1'b0, W'(8'h0A));
    step(1'b1, 1'b1, 1'b0, W'(8'h0B));
    chk_data("fwft_head_a", f_data, W'(8'h0A));
    step(1'b1, 1'b0, 1'b1, '0);
    chk_data("fwft_head_b", f_data, W'(8'h0B));

    // Random traffic with occasional mid-operation reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0, rand_data());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
